// File: rtl/bsg_mul_pp_feeder.sv
// Iterative unsigned partial-product generator: emits four shifted a*b[j] rows
// per 4-bit multiplier digit, terminating early once the remaining multiplier bits are zero.
module bsg_mul_pp_feeder #(
    parameter  int width_p      = 16,
    localparam int digits_lp    = width_p / 4,
    localparam int row_width_lp = width_p + 3,
    localparam int digit_w_lp   = (digits_lp > 1) ? $clog2(digits_lp) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               v_i,
    input  logic [width_p-1:0]                 a_i,
    input  logic [width_p-1:0]                 b_i,
    output logic                               ready_o,
    output logic                               v_o,
    output logic [3:0][row_width_lp-1:0]       rows_o,
    output logic [digit_w_lp-1:0]              digit_o,
    output logic                               last_o,
    input  logic                               yumi_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [width_p-1:0]     a_q, a_d;
    logic [width_p-1:0]     b_q, b_d;
    logic [digit_w_lp-1:0]  digit_q, digit_d;
    logic                   busy;
    logic                   last;

    assign busy = (state_q == BUSY);

    // b_q is consumed four bits at a time, so its upper bits going to zero means no more work.
    assign last = busy & (((b_q >> 4) == '0) | (digit_q == digit_w_lp'(digits_lp - 1)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        digit_d = digit_q;
        unique case (state_q)
            IDLE: begin
                if (v_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    digit_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (yumi_i) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        b_d     = b_q >> 4;
                        digit_d = digit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rows_o = '0;
        if (busy) begin
            for (int j = 0; j < 4; j++) begin
                rows_o[j] = row_width_lp'(a_q & {width_p{b_q[j]}}) << j;
            end
        end
    end

    assign ready_o = ~busy;
    assign v_o     = busy;
    assign digit_o = busy ? digit_q : '0;
    assign last_o  = last;

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !busy))
        else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_mul_pp_feeder.sv
// Scoreboard bench for bsg_mul_pp_feeder: directed corner cases followed by random
// operands with random downstream stalls, checked against an arithmetic digit model.
module tb_bsg_mul_pp_feeder;

    localparam int W  = 16;
    localparam int RW = W + 3;

    typedef struct packed {
        logic [3:0][RW-1:0] rows;
        logic [1:0]         digit;
        logic               last;
    } exp_t;

    logic                clk_i;
    logic                reset_n_i;
    logic                v_i;
    logic [W-1:0]        a_i;
    logic [W-1:0]        b_i;
    logic                ready_o;
    logic                v_o;
    logic [3:0][RW-1:0]  rows_o;
    logic [1:0]          digit_o;
    logic                last_o;
    logic                yumi_i;

    int total = 0;
    int bad   = 0;
    int stall_mode = 0;     // 0: consume at once, 1: random stalls, 2: three stall cycles per digit

    exp_t        exp_q[$];
    logic [63:0] prod_q[$];

    bsg_mul_pp_feeder #(.width_p(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .rows_o    (rows_o),
        .digit_o   (digit_o),
        .last_o    (last_o),
        .yumi_i    (yumi_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Digit d carries multiplier nibble (b >> 4d) & 0xF; row j is a<<j when that nibble's bit j is set.
    task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int         nd;
        int         msb;
        logic [3:0] nib;
        exp_t       e;
        if (b == 0) begin
            nd = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < W; i++) if (b[i]) msb = i;
            nd = 1 + msb / 4;
        end
        for (int d = 0; d < nd; d++) begin
            nib = 4'((b >> (4 * d)) & 16'hF);
            for (int j = 0; j < 4; j++) e.rows[j] = nib[j] ? (RW'(a) << j) : '0;
            e.digit = 2'(d);
            e.last  = (d == nd - 1);
            exp_q.push_back(e);
        end
        prod_q.push_back(64'(a) * 64'(b));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) chk(1'b0, "ready_timeout", {127'd0, ready_o}, 128'd1);
        push_model(a, b);
        v_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        chk(v_o == 1'b1, "accept_latency", {127'd0, v_o}, 128'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !ready_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0 || !ready_o) chk(1'b0, "drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: compares every presented digit against the queue head, drives yumi, and rebuilds the product.
    initial begin
        exp_t        e;
        logic [63:0] acc;
        logic [63:0] rsum;
        logic [63:0] p;
        int          stall_cnt;
        bit          expect_idle;
        acc = '0;
        stall_cnt = 0;
        expect_idle = 1'b0;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                yumi_i = 1'b0;
                acc = '0;
                stall_cnt = 0;
                expect_idle = 1'b0;
                continue;
            end
            if (expect_idle) begin
                chk(ready_o && !v_o, "idle_after_last", {126'd0, ready_o, v_o}, 128'b10);
                expect_idle = 1'b0;
            end
            chk(ready_o == !v_o, "ready_vs_valid", {126'd0, ready_o, v_o}, {126'd0, !v_o, v_o});
            if (!v_o) begin
                yumi_i = 1'b0;
                chk(rows_o == '0 && last_o == 1'b0, "quiet_outputs", {rows_o, last_o}, 128'd0);
            end else if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_digit", 128'(digit_o), 128'd0);
                yumi_i = 1'b1;
            end else begin
                e = exp_q[0];
                chk(rows_o == e.rows, "rows", 128'(rows_o), 128'(e.rows));
                chk(digit_o == e.digit, "digit", 128'(digit_o), 128'(e.digit));
                chk(last_o == e.last, "last", 128'(last_o), 128'(e.last));
                case (stall_mode)
                    1:       yumi_i = ($urandom_range(0, 3) != 0);
                    2:       yumi_i = (stall_cnt >= 3);
                    default: yumi_i = 1'b1;
                endcase
                if (yumi_i) begin
                    stall_cnt = 0;
                    void'(exp_q.pop_front());
                    rsum = 64'(rows_o[0]) + 64'(rows_o[1]) + 64'(rows_o[2]) + 64'(rows_o[3]);
                    acc = acc + (rsum << (4 * int'(digit_o)));
                    if (e.last) begin
                        p = (prod_q.size() != 0) ? prod_q.pop_front() : 64'hDEAD;
                        chk(acc == p, "product", 128'(acc), 128'(p));
                        acc = '0;
                        expect_idle = 1'b1;
                    end
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    initial begin
        int       n;
        logic [W-1:0] mask;
        reset_n_i = 1'b0;
        v_i = 1'b0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk(ready_o == 1'b1 && v_o == 1'b0, "reset_handshake", {126'd0, ready_o, v_o}, 128'b10);
        chk(rows_o == '0 && digit_o == '0 && last_o == 1'b0, "reset_outputs", {rows_o, digit_o, last_o}, 128'd0);

        // First accept on the very first rising edge after reset release.
        @(negedge clk_i);
        push_model(16'hFFFF, 16'hFFFF);
        v_i = 1'b1;
        a_i = 16'hFFFF;
        b_i = 16'hFFFF;
        #2 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        chk(v_o == 1'b1, "first_accept", {127'd0, v_o}, 128'd1);
        drain();

        issue(16'h1234, 16'h0003);
        drain();
        issue(16'hBEEF, 16'h0000);
        drain();

        // Backpressure with v_i pulses that must be ignored while busy.
        stall_mode = 2;
        issue(16'h00FF, 16'h0F0F);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (!ready_o) begin
                v_i = 1'b1;
                a_i = W'($urandom);
                b_i = W'($urandom);
                @(posedge clk_i);
                #1;
                v_i = 1'b0;
            end
        end
        drain();

        // Reset in the middle of digit 1 abandons the operation.
        stall_mode = 0;
        issue(16'hFFFF, 16'hFFFF);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(v_o && digit_o == 2'd1) && n < 20);
        if (!(v_o && digit_o == 2'd1)) chk(1'b0, "digit1_timeout", 128'(digit_o), 128'd1);
        #2 reset_n_i = 1'b0;
        #1;
        chk(v_o == 1'b0 && ready_o == 1'b1, "midop_reset_handshake", {126'd0, ready_o, v_o}, 128'b10);
        chk(rows_o == '0 && digit_o == '0 && last_o == 1'b0, "midop_reset_outputs", {rows_o, digit_o, last_o}, 128'd0);
        exp_q.delete();
        prod_q.delete();
        repeat (2) @(negedge clk_i);
        #2 reset_n_i = 1'b1;
        issue(16'd2, 16'd3);
        drain();

        stall_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       mask = 16'h0000;
                1:       mask = 16'h000F;
                2:       mask = 16'h00FF;
                3:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            issue(W'($urandom), W'($urandom) & mask);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
